// File: rtl/encoder_4x2_pending_pkg.sv
// Shared definitions for the sequential 4-to-2 pending-event encoder.
// Holds line/index widths, FSM encoding and a one-hot helper.
package encoder_4x2_pending_pkg;

  localparam int IDX_W   = 2;
  localparam int N_LINES = 4;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  function automatic logic [N_LINES-1:0] idx_mask(
    input logic [IDX_W-1:0] i
  );
    logic [N_LINES-1:0] m;
    m    = '0;
    m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/encoder_4x2_pending_prio_sel.sv
// Combinational 4-way selector: fixed (highest index wins) or
// round-robin starting at 'start' and wrapping modulo 4.
module prio_sel_4
  import encoder_4x2_pending_pkg::*;
(
  input  logic [N_LINES-1:0] req,
  input  logic [IDX_W-1:0]   start,
  input  logic               rr_en,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] j;

  always_comb begin
    idx = '0;
    j   = '0;
    any = |req;
    if (rr_en) begin
      // walk backwards so the entry nearest 'start' is written last
      for (int k = N_LINES-1; k >= 0; k--) begin
        j = start + IDX_W'(k);
        if (req[j]) idx = j;
      end
    end else begin
      for (int k = 0; k < N_LINES; k++) begin
        if (req[k]) idx = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/encoder_4x2_pending.sv
// Sticky pending-event collector emitting one 2-bit line index per
// valid/ready transfer, back-to-back while events remain pending.
module encoder_4x2_pending
  import encoder_4x2_pending_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       d3,
  input  logic       d2,
  input  logic       d1,
  input  logic       d0,
  input  logic       ready,
  output logic       a1,
  output logic       a0,
  output logic       valid,
  output logic [3:0] pend,
  output logic       merged
);

  state_t             state;
  logic [N_LINES-1:0] d;
  logic [N_LINES-1:0] pend_r;
  logic [N_LINES-1:0] pend_in;
  logic [IDX_W-1:0]   a_r;
  logic [IDX_W-1:0]   last;
  logic [IDX_W-1:0]   start;
  logic [IDX_W-1:0]   sel;
  logic               any;
  logic               merged_r;

  assign d       = {d3, d2, d1, d0};
  assign pend_in = pend_r | d;
  assign start   = last + 2'd1;

  prio_sel_4 u_sel (
    .req   (pend_in),
    .start (start),
    .rr_en (ROUND_ROBIN),
    .idx   (sel),
    .any   (any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      a_r      <= '0;
      pend_r   <= '0;
      last     <= 2'd3;
      merged_r <= 1'b0;
    end else begin
      merged_r <= |(d & pend_r);
      unique case (state)
        ST_IDLE: begin
          if (any) begin
            a_r    <= sel;
            pend_r <= pend_in & ~idx_mask(sel);
            last   <= sel;
            state  <= ST_PRESENT;
          end else begin
            pend_r <= pend_in;
          end
        end
        ST_PRESENT: begin
          if (!ready) begin
            pend_r <= pend_in;
          end else if (any) begin
            a_r    <= sel;
            pend_r <= pend_in & ~idx_mask(sel);
            last   <= sel;
          end else begin
            pend_r <= pend_in;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign a1     = a_r[1];
  assign a0     = a_r[0];
  assign valid  = (state == ST_PRESENT);
  assign pend   = pend_r;
  assign merged = merged_r;

endmodule
